// File: rtl/gol_pkg.sv
// Shared board geometry, editor state encoding and cell addressing for the 16x16 board.
package gol_pkg;
    localparam int BOARD_DIM   = 16;
    localparam int BOARD_CELLS = 256;
    localparam int CELL_IDX_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Row-major flat index: row*16 + col is just the concatenation of the two nibbles.
    function automatic logic [CELL_IDX_W-1:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability debouncer and a one-cycle
// pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Counter runs only while the synchronised input disagrees with the accepted level,
    // so any sample matching the old level throws the partial count away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_q <= level;
            press   <= level & ~level_q;
        end
    end
endmodule

// File: rtl/board_editor.sv
// Board writer: cursor-driven cell editing with debounced buttons, and a valid/ready
// commit of the finished board to the game machine.
module board_editor
    import gol_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         BtnL,
    input  logic                         BtnR,
    input  logic                         BtnU,
    input  logic                         BtnD,
    input  logic                         BtnC,
    input  logic                         edit_en,
    input  logic                         clear_i,
    input  logic                         load_ready,
    output logic [BOARD_CELLS-1:0]       board_o,
    output logic                         load_valid,
    output logic [$clog2(BOARD_DIM)-1:0] cursor_row,
    output logic [$clog2(BOARD_DIM)-1:0] cursor_col,
    output logic                         cursor_vis,
    output logic                         editing
);
    localparam int               POS_W     = $clog2(BOARD_DIM);
    localparam int               BLINK_W   = $clog2(BLINK_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

    state_t             state;
    logic               press_l;
    logic               press_r;
    logic               press_u;
    logic               press_d;
    logic               press_c;
    logic               edit_s1;
    logic               edit_s2;
    logic               clr_s1;
    logic               clr_s2;
    logic               clr_prev;
    logic               clr_rise;
    logic [BLINK_W-1:0] blink_cnt;
    logic [POS_W-1:0]   row_next;
    logic [POS_W-1:0]   col_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (.clk(clk), .reset(reset), .raw(BtnL), .press(press_l));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (.clk(clk), .reset(reset), .raw(BtnR), .press(press_r));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (.clk(clk), .reset(reset), .raw(BtnU), .press(press_u));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (.clk(clk), .reset(reset), .raw(BtnD), .press(press_d));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (.clk(clk), .reset(reset), .raw(BtnC), .press(press_c));

    // Switches are slow levels, so they get synchronised but not debounced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edit_s1  <= 1'b0;
            edit_s2  <= 1'b0;
            clr_s1   <= 1'b0;
            clr_s2   <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            edit_s1  <= edit_en;
            edit_s2  <= edit_s1;
            clr_s1   <= clear_i;
            clr_s2   <= clr_s1;
            clr_prev <= clr_s2;
        end
    end

    assign clr_rise = clr_s2 & ~clr_prev;

    // Opposing presses in the same cycle cancel; the 4-bit add/subtract gives the wrap.
    always_comb begin
        col_next = cursor_col;
        row_next = cursor_row;
        if (press_r && !press_l) col_next = cursor_col + 1'b1;
        if (press_l && !press_r) col_next = cursor_col - 1'b1;
        if (press_d && !press_u) row_next = cursor_row + 1'b1;
        if (press_u && !press_d) row_next = cursor_row - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            board_o    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            load_valid <= 1'b0;
            editing    <= 1'b0;
            cursor_vis <= 1'b0;
            blink_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (edit_s2) begin
                        state      <= ST_EDIT;
                        editing    <= 1'b1;
                        cursor_vis <= 1'b1;
                        blink_cnt  <= '0;
                    end
                end
                ST_EDIT: begin
                    cursor_row <= row_next;
                    cursor_col <= col_next;
                    // Toggle addresses the pre-move cursor; a clear in the same cycle overrides it.
                    if (clr_rise) begin
                        board_o <= '0;
                    end else if (press_c) begin
                        board_o[cell_idx(cursor_row, cursor_col)] <= ~board_o[cell_idx(cursor_row, cursor_col)];
                    end
                    if (blink_cnt == BLINK_MAX) begin
                        cursor_vis <= ~cursor_vis;
                        blink_cnt  <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                    if (!edit_s2) begin
                        state      <= ST_COMMIT;
                        load_valid <= 1'b1;
                        editing    <= 1'b0;
                        cursor_vis <= 1'b0;
                        blink_cnt  <= '0;
                    end
                end
                ST_COMMIT: begin
                    if (load_ready) begin
                        state      <= ST_IDLE;
                        load_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    load_valid <= 1'b0;
                    editing    <= 1'b0;
                    cursor_vis <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_editor.sv
// Randomised and directed bench for board_editor, checked against a cursor/board model
// that applies the editing rules with plain arithmetic.
module tb_board_editor;
    localparam int DEB   = 4;
    localparam int BLINK = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         BtnL, BtnR, BtnU, BtnD, BtnC;
    logic         edit_en, clear_i, load_ready;
    logic [255:0] board_o;
    logic         load_valid;
    logic [3:0]   cursor_row, cursor_col;
    logic         cursor_vis, editing;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [255:0] m_board;
    int           m_row, m_col;

    board_editor #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLINK)) dut (
        .clk(clk), .reset(reset),
        .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
        .edit_en(edit_en), .clear_i(clear_i), .load_ready(load_ready),
        .board_o(board_o), .load_valid(load_valid),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .cursor_vis(cursor_vis), .editing(editing)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bits: 0=L 1=R 2=U 3=D 4=C
    task automatic set_buttons(input logic [4:0] m);
        BtnL = m[0]; BtnR = m[1]; BtnU = m[2]; BtnD = m[3]; BtnC = m[4];
    endtask

    task automatic press(input logic [4:0] m);
        set_buttons(m);
        cycles(10);
        set_buttons(5'b0);
        cycles(10);
    endtask

    task automatic model_press(input logic [4:0] m);
        int dc, dr;
        if (m[4]) m_board[m_row*16 + m_col] = ~m_board[m_row*16 + m_col];
        dc = int'(m[1]) - int'(m[0]);
        dr = int'(m[3]) - int'(m[2]);
        m_col = (m_col + dc + 16) % 16;
        m_row = (m_row + dr + 16) % 16;
    endtask

    task automatic goto_cell(input int r, input int c);
        while (m_col != c) begin press(5'b00010); model_press(5'b00010); end
        while (m_row != r) begin press(5'b01000); model_press(5'b01000); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_buttons(5'b0);
        edit_en = 1'b0; clear_i = 1'b0; load_ready = 1'b0;
        cycles(3);
        n_cmp++; if (board_o !== '0) begin n_fail++; $display("FAIL reset_board: got %h want 0", board_o); end
        n_cmp++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", load_valid); end
        n_cmp++; if ({cursor_row, cursor_col} !== 8'h00) begin n_fail++; $display("FAIL reset_cursor: got %h want 00", {cursor_row, cursor_col}); end
        n_cmp++; if (cursor_vis !== 1'b0) begin n_fail++; $display("FAIL reset_vis: got %b want 0", cursor_vis); end
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL reset_editing: got %b want 0", editing); end
        reset = 1'b0;
        m_board = '0; m_row = 0; m_col = 0;
    endtask

    task automatic test_enter_blink;
        int k;
        logic exp_vis;
        edit_en = 1'b1;
        k = 0;
        while (editing !== 1'b1 && k < 20) begin cycles(1); k++; end
        n_cmp++; if (k != 3) begin n_fail++; $display("FAIL edit_entry_latency: got %0d want 3", k); end
        for (int i = 0; i < 4 * BLINK; i++) begin
            exp_vis = ((i / BLINK) % 2) == 0;
            n_cmp++; if (cursor_vis !== exp_vis) begin n_fail++; $display("FAIL blink_%0d: got %b want %b", i, cursor_vis, exp_vis); end
            cycles(1);
        end
    endtask

    task automatic test_press_latency;
        int k;
        BtnC = 1'b1;
        k = 0;
        while (board_o === '0 && k < 30) begin cycles(1); k++; end
        n_cmp++; if (k != DEB + 4) begin n_fail++; $display("FAIL press_latency: got %0d want %0d", k, DEB + 4); end
        if (k < 10) cycles(10 - k);
        BtnC = 1'b0;
        cycles(12);
        model_press(5'b10000);
        n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL hold_single_toggle: got %h want %h", board_o, m_board); end
    endtask

    task automatic test_glitch;
        BtnC = 1'b1;
        cycles(2);
        BtnC = 1'b0;
        cycles(15);
        n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL glitch: got %h want %h", board_o, m_board); end
    endtask

    task automatic test_wrap;
        logic [4:0] seq [5];
        seq[0] = 5'b00001; seq[1] = 5'b00100; seq[2] = 5'b10000; seq[3] = 5'b00010; seq[4] = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            press(seq[i]);
            model_press(seq[i]);
            n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL wrap_board_%0d: got %h want %h", i, board_o, m_board); end
            n_cmp++; if ({cursor_row, cursor_col} !== {4'(m_row), 4'(m_col)}) begin
                n_fail++; $display("FAIL wrap_cursor_%0d: got %h want %h", i, {cursor_row, cursor_col}, {4'(m_row), 4'(m_col)});
            end
        end
        n_cmp++; if (board_o[255] !== 1'b1) begin n_fail++; $display("FAIL wrap_bit255: got %b want 1", board_o[255]); end
    endtask

    task automatic test_simultaneous;
        int old_col, old_row;
        old_col = m_col; old_row = m_row;
        press(5'b01011);
        model_press(5'b01011);
        n_cmp++; if ({cursor_row, cursor_col} !== {4'(old_row + 1), 4'(old_col)}) begin
            n_fail++; $display("FAIL lr_cancel: got %h want %h", {cursor_row, cursor_col}, {4'(old_row + 1), 4'(old_col)});
        end
        goto_cell(2, 3);
        press(5'b10010);
        model_press(5'b10010);
        n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL c_plus_r_board: got %h want %h", board_o, m_board); end
        n_cmp++; if (cursor_col !== 4'd4) begin n_fail++; $display("FAIL c_plus_r_col: got %0d want 4", cursor_col); end
    endtask

    task automatic test_clear;
        goto_cell(1, 1); press(5'b10000); model_press(5'b10000);
        goto_cell(2, 2); press(5'b10000); model_press(5'b10000);
        n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL pre_clear: got %h want %h", board_o, m_board); end
        clear_i = 1'b1;
        cycles(2);
        n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL clear_early: got %h want %h", board_o, m_board); end
        cycles(1);
        m_board = '0;
        n_cmp++; if (board_o !== '0) begin n_fail++; $display("FAIL clear: got %h want 0", board_o); end
        clear_i = 1'b0;
        cycles(3);
        press(5'b10000); model_press(5'b10000);
        press(5'b00010); model_press(5'b00010);
        n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL pre_clear_c: got %h want %h", board_o, m_board); end
        BtnC = 1'b1;
        cycles(5);
        clear_i = 1'b1;
        cycles(5);
        BtnC = 1'b0;
        cycles(10);
        m_board = '0;
        n_cmp++; if (board_o !== '0) begin n_fail++; $display("FAIL clear_beats_c: got %h want 0", board_o); end
        clear_i = 1'b0;
        cycles(3);
    endtask

    task automatic test_random;
        logic [4:0] m;
        for (int i = 0; i < 25; i++) begin
            m = 5'($urandom_range(1, 31));
            press(m);
            model_press(m);
            n_cmp++; if (board_o !== m_board || {cursor_row, cursor_col} !== {4'(m_row), 4'(m_col)}) begin
                n_fail++;
                $display("FAIL random_%0d mask %b: got cur %h board %h want cur %h board %h", i, m,
                         {cursor_row, cursor_col}, board_o, {4'(m_row), 4'(m_col)}, m_board);
            end
        end
    endtask

    task automatic test_commit;
        int k;
        edit_en = 1'b0;
        k = 0;
        while (load_valid !== 1'b1 && k < 10) begin cycles(1); k++; end
        n_cmp++; if (k != 3) begin n_fail++; $display("FAIL commit_latency: got %0d want 3", k); end
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL commit_editing: got %b want 0", editing); end
        for (int i = 0; i < 20; i++) begin
            if (i == 2) BtnC = 1'b1;
            if (i == 10) edit_en = 1'b1;
            n_cmp++; if (load_valid !== 1'b1) begin n_fail++; $display("FAIL commit_hold_valid_%0d: got %b want 1", i, load_valid); end
            n_cmp++; if (board_o !== m_board) begin n_fail++; $display("FAIL commit_frozen_%0d: got %h want %h", i, board_o, m_board); end
            cycles(1);
        end
        BtnC = 1'b0;
        load_ready = 1'b1;
        cycles(1);
        load_ready = 1'b0;
        n_cmp++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL accept_valid: got %b want 0", load_valid); end
        n_cmp++; if (editing !== 1'b0) begin n_fail++; $display("FAIL accept_idle: got %b want 0", editing); end
        cycles(1);
        n_cmp++; if (editing !== 1'b1) begin n_fail++; $display("FAIL reenter_edit: got %b want 1", editing); end
        n_cmp++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL single_handshake: got %b want 0", load_valid); end
        cycles(10);
    endtask

    task automatic test_reset_mid_commit;
        int k;
        press(5'b10000); model_press(5'b10000);
        edit_en = 1'b0;
        k = 0;
        while (load_valid !== 1'b1 && k < 10) begin cycles(1); k++; end
        n_cmp++; if (load_valid !== 1'b1) begin n_fail++; $display("FAIL midcommit_valid: got %b want 1", load_valid); end
        cycles(2);
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", load_valid); end
        n_cmp++; if (board_o !== '0) begin n_fail++; $display("FAIL async_board: got %h want 0", board_o); end
        m_board = '0; m_row = 0; m_col = 0;
        @(negedge clk);
        reset = 1'b0;
        press(5'b10010);
        for (int i = 0; i < 12; i++) begin
            n_cmp++; if (cursor_vis !== 1'b0 || editing !== 1'b0) begin
                n_fail++; $display("FAIL idle_vis_%0d: got vis %b edit %b want 0 0", i, cursor_vis, editing);
            end
            cycles(1);
        end
        n_cmp++; if (board_o !== m_board || {cursor_row, cursor_col} !== 8'h00) begin
            n_fail++; $display("FAIL idle_ignores: got cur %h board %h want 00 0", {cursor_row, cursor_col}, board_o);
        end
    endtask

    initial begin
        test_reset();
        test_enter_blink();
        test_press_latency();
        test_glitch();
        test_wrap();
        test_simultaneous();
        test_clear();
        test_random();
        test_commit();
        test_reset_mid_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] bench timed out");
    end
endmodule
